// File: rtl/ann_pkg.sv
// Shared definitions for the ANN reduction stages: data width, FSM states,
// saturation constant and index-width helper.
package ann_pkg;

  localparam int ANN_DW = 16;
  localparam logic [ANN_DW-1:0] ANN_MAX_POS = {1'b0, {(ANN_DW-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } ann_state_e;

  // A single class still needs a one-bit index.
  function automatic int ann_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ann_argmax_classifier_if.sv
// Handshake/result bundle for ann_argmax_classifier. out_margin exists only
// when ARGMAX_MARGIN_EN is defined.
interface ann_argmax_classifier_if
  import ann_pkg::*;
#(
  parameter int N_IN = 15,
  parameter int DW   = ANN_DW,
  parameter int IW   = ann_idx_w(N_IN)
);

  logic                 start;
  logic [N_IN*DW-1:0]   in_vec;
  logic                 busy;
  logic                 out_valid;
  logic [IW-1:0]        out_class;
  logic [DW-1:0]        out_value;
`ifdef ARGMAX_MARGIN_EN
  logic [DW-1:0]        out_margin;

  modport master (
    output start, in_vec,
    input  busy, out_valid, out_class, out_value, out_margin
  );

  modport slave (
    input  start, in_vec,
    output busy, out_valid, out_class, out_value, out_margin
  );
`else
  modport master (
    output start, in_vec,
    input  busy, out_valid, out_class, out_value
  );

  modport slave (
    input  start, in_vec,
    output busy, out_valid, out_class, out_value
  );
`endif

endinterface

// File: rtl/ann_max_update.sv
// Combinational running-max step shared by reduction stages; also tracks the
// runner-up when ARGMAX_MARGIN_EN is defined.
module ann_max_update
  import ann_pkg::*;
#(
  parameter int DW = ANN_DW
) (
  input  logic [DW-1:0] best_i,
  input  logic [DW-1:0] cand_i,
`ifdef ARGMAX_MARGIN_EN
  input  logic [DW-1:0] second_i,
  output logic [DW-1:0] second_o,
`endif
  output logic [DW-1:0] best_o,
  output logic          take_o
);

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    take_o = $signed(cand_i) > $signed(best_i);
    best_o = take_o ? cand_i : best_i;
  end

`ifdef ARGMAX_MARGIN_EN
  always_comb begin
    second_o = second_i;
    if (take_o) begin
      second_o = best_i;
    end else if ($signed(cand_i) > $signed(second_i)) begin
      second_o = cand_i;
    end
  end
`endif

endmodule

// File: rtl/ann_argmax_classifier.sv
// Argmax over N_IN signed activations: parallel capture, one element per clock.
// Optional best-minus-second margin output under ARGMAX_MARGIN_EN.
//
// state | meaning
// IDLE  | waiting for start; results held
// SCAN  | comparing buffer[cnt] against running best, busy=1
// DONE  | result registers just updated, out_valid=1; start accepted here too
module ann_argmax_classifier
  import ann_pkg::*;
#(
  parameter int N_IN = 15,
  parameter int DW   = ANN_DW,
  parameter int IW   = ann_idx_w(N_IN)
) (
  input  logic                   clk,
  input  logic                   reset,
  ann_argmax_classifier_if.slave ctrl_if
);

  localparam logic [IW-1:0] LAST = IW'(N_IN - 1);

  ann_state_e    state_q;
  logic [DW-1:0] buf_q [N_IN];
  logic [DW-1:0] best_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] cnt_q;
  logic          busy_q;
  logic          valid_q;
  logic [IW-1:0] class_q;
  logic [DW-1:0] value_q;

  logic [DW-1:0] cand;
  logic [DW-1:0] best_d;
  logic          take;

  assign cand = buf_q[cnt_q];

`ifdef ARGMAX_MARGIN_EN
  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] second_q;
  logic [DW-1:0] second_d;
  logic [DW-1:0] margin_q;
  logic [DW-1:0] margin_d;
  logic [DW:0]   diff;

  ann_max_update #(.DW(DW)) u_max_update (
    .best_i   (best_q),
    .cand_i   (cand),
    .second_i (second_q),
    .second_o (second_d),
    .best_o   (best_d),
    .take_o   (take)
  );

  // best >= second always, so the widened difference is non-negative.
  assign diff     = {best_d[DW-1], best_d} - {second_d[DW-1], second_d};
  assign margin_d = (diff > {1'b0, MAX_POS}) ? MAX_POS : diff[DW-1:0];
`else
  ann_max_update #(.DW(DW)) u_max_update (
    .best_i (best_q),
    .cand_i (cand),
    .best_o (best_d),
    .take_o (take)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      class_q <= '0;
      value_q <= '0;
      for (int k = 0; k < N_IN; k++) begin
        buf_q[k] <= '0;
      end
`ifdef ARGMAX_MARGIN_EN
      second_q <= '0;
      margin_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          best_q <= best_d;
          if (take) begin
            idx_q <= cnt_q;
          end
          cnt_q <= cnt_q + 1'b1;
`ifdef ARGMAX_MARGIN_EN
          second_q <= second_d;
`endif
          if (cnt_q == LAST) begin
            class_q <= take ? cnt_q : idx_q;
            value_q <= best_d;
`ifdef ARGMAX_MARGIN_EN
            margin_q <= margin_d;
`endif
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        default: begin
          if (ctrl_if.start) begin
            for (int k = 0; k < N_IN; k++) begin
              buf_q[k] <= ctrl_if.in_vec[k*DW +: DW];
            end
            best_q <= ctrl_if.in_vec[DW-1:0];
            idx_q  <= '0;
            cnt_q  <= IW'(1);
`ifdef ARGMAX_MARGIN_EN
            second_q <= MIN_NEG;
`endif
            if (N_IN > 1) begin
              state_q <= SCAN;
              busy_q  <= 1'b1;
            end else begin
              // Single class: nothing to scan, result is element 0.
              state_q <= DONE;
              valid_q <= 1'b1;
              class_q <= '0;
              value_q <= ctrl_if.in_vec[DW-1:0];
`ifdef ARGMAX_MARGIN_EN
              margin_q <= MAX_POS;
`endif
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign ctrl_if.busy      = busy_q;
  assign ctrl_if.out_valid = valid_q;
  assign ctrl_if.out_class = class_q;
  assign ctrl_if.out_value = value_q;
`ifdef ARGMAX_MARGIN_EN
  assign ctrl_if.out_margin = margin_q;
`endif

endmodule

// File: tb/tb_ann_argmax_classifier.sv
// Scoreboard bench for ann_argmax_classifier; margin checks active when
// ARGMAX_MARGIN_EN is defined.
module tb_ann_argmax_classifier;
  import ann_pkg::*;

  localparam int N_IN = 15;
  localparam int DW   = ANN_DW;
  localparam int IW   = ann_idx_w(N_IN);
  localparam int BUDGET = 2 * N_IN + 8;

  typedef logic [DW-1:0] vec_t [N_IN];
  typedef struct {
    int            idx;
    logic [DW-1:0] val;
    logic [DW-1:0] margin;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ann_argmax_classifier_if #(.N_IN(N_IN), .DW(DW), .IW(IW)) dut_if ();

  ann_argmax_classifier #(.N_IN(N_IN), .DW(DW), .IW(IW)) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (dut_if)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input vec_t v);
    exp_t e;
    int bi, bv, sv, dd;
    bit found;
    bi = 0;
    for (int k = 1; k < N_IN; k++)
      if ($signed(v[k]) > $signed(v[bi])) bi = k;
    e.idx = bi;
    e.val = v[bi];
    bv = $signed(v[bi]);
    found = 0;
    sv = 0;
    for (int k = 0; k < N_IN; k++) begin
      if (k != bi && (!found || $signed(v[k]) > sv)) begin
        sv = $signed(v[k]);
        found = 1;
      end
    end
    dd = found ? (bv - sv) : 32'h7fff_ffff;
    e.margin = (dd > int'(ANN_MAX_POS)) ? ANN_MAX_POS : DW'(dd);
    e.due = 0;
    return e;
  endfunction

  function automatic logic [N_IN*DW-1:0] pack(input vec_t v);
    logic [N_IN*DW-1:0] p;
    for (int k = 0; k < N_IN; k++) p[k*DW +: DW] = v[k];
    return p;
  endfunction

  function automatic vec_t fill(input logic [DW-1:0] x);
    vec_t v;
    for (int k = 0; k < N_IN; k++) v[k] = x;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int mode;
    mode = $urandom_range(0, 3);
    for (int k = 0; k < N_IN; k++) begin
      case (mode)
        0: v[k] = DW'($urandom);
        1: v[k] = DW'($urandom_range(0, 7));
        2: v[k] = DW'($urandom_range(0, 32767));
        default: v[k] = DW'(-int'($urandom_range(1, 32768)));
      endcase
    end
    return v;
  endfunction

  // Call between edges while the DUT is in IDLE or DONE; returns just after the capture edge.
  task automatic drive_start(input vec_t v);
    exp_t e;
    e = model(v);
    dut_if.start  = 1'b1;
    dut_if.in_vec = pack(v);
    @(posedge clk);
    #1;
    e.due = cyc + N_IN - 1;
    sb.push_back(e);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (dut_if.out_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dut_if.start = 1'b0;
    dut_if.in_vec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dut_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", dut_if.busy); end
    checks++; if (dut_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dut_if.out_valid); end
    checks++; if (dut_if.out_class !== '0) begin errors++; $display("FAIL reset_class: got %0d want 0", dut_if.out_class); end
    checks++; if (dut_if.out_value !== '0) begin errors++; $display("FAIL reset_value: got %h want 0", dut_if.out_value); end
`ifdef ARGMAX_MARGIN_EN
    checks++; if (dut_if.out_margin !== '0) begin errors++; $display("FAIL reset_margin: got %h want 0", dut_if.out_margin); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_single_peak();
    vec_t v;
    exp_t e;
    bit ok;
    v = fill('0);
    v[9] = 16'd500;
    drive_start(v);
    dut_if.start = 1'b0;
    @(negedge clk);
    checks++; if (dut_if.busy !== 1'b1) begin errors++; $display("FAIL peak_busy: got %b want 1", dut_if.busy); end
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL peak_timeout: no out_valid within %0d cycles", BUDGET); end
    else begin
      e = sb.pop_front();
      checks++; if (cyc !== e.due) begin errors++; $display("FAIL peak_latency: got cycle %0d want %0d", cyc, e.due); end
      checks++; if (dut_if.out_class !== IW'(e.idx)) begin errors++; $display("FAIL peak_class: got %0d want %0d", dut_if.out_class, e.idx); end
      checks++; if (dut_if.out_value !== e.val) begin errors++; $display("FAIL peak_value: got %h want %h", dut_if.out_value, e.val); end
    end
    @(negedge clk);
    checks++; if (dut_if.out_valid !== 1'b0) begin errors++; $display("FAIL peak_pulse: got %b want 0", dut_if.out_valid); end
    checks++; if (dut_if.out_class !== 4'd9) begin errors++; $display("FAIL peak_hold: got %0d want 9", dut_if.out_class); end
  endtask

  task automatic test_tie();
    vec_t v;
    exp_t e;
    bit ok;
    v = fill(16'd100);
    v[3] = 16'd1200;
    v[11] = 16'd1200;
    drive_start(v);
    dut_if.start = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tie_timeout: no out_valid within %0d cycles", BUDGET); end
    else begin
      e = sb.pop_front();
      checks++; if (dut_if.out_class !== IW'(e.idx)) begin errors++; $display("FAIL tie_class: got %0d want %0d", dut_if.out_class, e.idx); end
      checks++; if (dut_if.out_value !== e.val) begin errors++; $display("FAIL tie_value: got %h want %h", dut_if.out_value, e.val); end
`ifdef ARGMAX_MARGIN_EN
      checks++; if (dut_if.out_margin !== e.margin) begin errors++; $display("FAIL tie_margin: got %h want %h", dut_if.out_margin, e.margin); end
`endif
    end
  endtask

  task automatic test_signed();
    vec_t v [2];
    exp_t e;
    bit ok;
    v[0] = fill(16'hFF9C);
    v[0][0] = 16'hFFFB;
    v[0][1] = 16'hFFFE;
    v[1] = fill(16'h8000);
    v[1][7] = 16'h7FFF;
    for (int t = 0; t < 2; t++) begin
      drive_start(v[t]);
      dut_if.start = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL signed_timeout: vector %0d no out_valid", t); end
      else begin
        e = sb.pop_front();
        checks++; if (dut_if.out_class !== IW'(e.idx)) begin errors++; $display("FAIL signed_class: vector %0d got %0d want %0d", t, dut_if.out_class, e.idx); end
        checks++; if (dut_if.out_value !== e.val) begin errors++; $display("FAIL signed_value: vector %0d got %h want %h", t, dut_if.out_value, e.val); end
`ifdef ARGMAX_MARGIN_EN
        checks++; if (dut_if.out_margin !== e.margin) begin errors++; $display("FAIL signed_margin: vector %0d got %h want %h", t, dut_if.out_margin, e.margin); end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v1, v2;
    exp_t e;
    bit ok;
    int first, extra;
    v1 = fill(16'd10);
    v1[5] = 16'd900;
    v2 = fill('0);
    v2[14] = 16'd7;
    drive_start(v1);
    // start stays high and in_vec changes during SCAN; neither may disturb the scan.
    dut_if.in_vec = pack(fill(16'd30000));
    wait_valid(ok);
    first = cyc;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first_timeout: no out_valid within %0d cycles", BUDGET); end
    else begin
      e = sb.pop_front();
      checks++; if (cyc !== e.due) begin errors++; $display("FAIL b2b_first_latency: got cycle %0d want %0d", cyc, e.due); end
      checks++; if (dut_if.out_class !== IW'(e.idx)) begin errors++; $display("FAIL b2b_first_class: got %0d want %0d", dut_if.out_class, e.idx); end
      checks++; if (dut_if.out_value !== e.val) begin errors++; $display("FAIL b2b_first_value: got %h want %h", dut_if.out_value, e.val); end
    end
    drive_start(v2);
    dut_if.start = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_second_timeout: no out_valid within %0d cycles", BUDGET); end
    else begin
      e = sb.pop_front();
      checks++; if (cyc !== first + N_IN) begin errors++; $display("FAIL b2b_spacing: got cycle %0d want %0d", cyc, first + N_IN); end
      checks++; if (dut_if.out_class !== IW'(e.idx)) begin errors++; $display("FAIL b2b_second_class: got %0d want %0d", dut_if.out_class, e.idx); end
      checks++; if (dut_if.out_value !== e.val) begin errors++; $display("FAIL b2b_second_value: got %h want %h", dut_if.out_value, e.val); end
    end
    extra = 0;
    for (int i = 0; i < 2 * N_IN; i++) begin
      @(negedge clk);
      if (dut_if.out_valid === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_valid: got %0d pulses want 0", extra); end
  endtask

  task automatic test_reset_midscan();
    vec_t v;
    exp_t e;
    bit ok;
    int seen;
    v = fill(16'd3);
    v[2] = 16'd4000;
    drive_start(v);
    dut_if.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    checks++; if (dut_if.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", dut_if.busy); end
    checks++; if (dut_if.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", dut_if.out_valid); end
    checks++; if (dut_if.out_class !== '0) begin errors++; $display("FAIL midrst_class: got %0d want 0", dut_if.out_class); end
    checks++; if (dut_if.out_value !== '0) begin errors++; $display("FAIL midrst_value: got %h want 0", dut_if.out_value); end
`ifdef ARGMAX_MARGIN_EN
    checks++; if (dut_if.out_margin !== '0) begin errors++; $display("FAIL midrst_margin: got %h want 0", dut_if.out_margin); end
`endif
    seen = 0;
    for (int i = 0; i < N_IN + 4; i++) begin
      @(negedge clk);
      if (dut_if.out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_ghost_valid: got %0d pulses want 0", seen); end
    v = fill(16'd50);
    v[12] = 16'd60;
    drive_start(v);
    dut_if.start = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_after_timeout: no out_valid within %0d cycles", BUDGET); end
    else begin
      e = sb.pop_front();
      checks++; if (cyc !== e.due) begin errors++; $display("FAIL midrst_after_latency: got cycle %0d want %0d", cyc, e.due); end
      checks++; if (dut_if.out_class !== IW'(e.idx)) begin errors++; $display("FAIL midrst_after_class: got %0d want %0d", dut_if.out_class, e.idx); end
      checks++; if (dut_if.out_value !== e.val) begin errors++; $display("FAIL midrst_after_value: got %h want %h", dut_if.out_value, e.val); end
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit ok;
    int gap;
    @(negedge clk);
    drive_start(rand_vec());
    dut_if.start = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      wait_valid(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_timeout: vector %0d no out_valid within %0d cycles", n, BUDGET);
        break;
      end
      e = sb.pop_front();
      checks++; if (cyc !== e.due) begin errors++; $display("FAIL rand_latency: vector %0d got cycle %0d want %0d", n, cyc, e.due); end
      checks++; if (dut_if.out_class !== IW'(e.idx)) begin errors++; $display("FAIL rand_class: vector %0d got %0d want %0d", n, dut_if.out_class, e.idx); end
      checks++; if (dut_if.out_value !== e.val) begin errors++; $display("FAIL rand_value: vector %0d got %h want %h", n, dut_if.out_value, e.val); end
`ifdef ARGMAX_MARGIN_EN
      checks++; if (dut_if.out_margin !== e.margin) begin errors++; $display("FAIL rand_margin: vector %0d got %h want %h", n, dut_if.out_margin, e.margin); end
`endif
      if (n < 999) begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        drive_start(rand_vec());
        dut_if.start = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_tie();
    test_signed();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ann_argmax_classifier.md
Name: ann_argmax_classifier

Overview:
- Final classification stage of the fixed-point ECG network; it sits directly downstream of the last layer of ReLU nodes.
- On `start`, it captures all node outputs in parallel, then scans them sequentially, one element per clock.
- It reports the index and value of the largest activation with a one-cycle `out_valid` pulse.
- Results are held until the next accepted `start` or `reset`.

Parameters:
- N_IN, 15, number of upstream node outputs (classes); legal range 1..64.
- DW, 16, width of each activation, two's complement.
- IW, $clog2(N_IN) (min 1), width of the class index.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to capture `in_vec` and begin a scan.
- in_vec  input  N_IN*DW  packed node outputs; element k is in_vec[k*DW +: DW] (node N0x at k=0).
- busy  output  1  high while a scan is in progress (state SCAN).
- out_valid  output  1  one-cycle pulse when the result registers update.
- out_class  output  IW  index of the maximum element.
- out_value  output  DW  value of the maximum element.
- out_margin  output  DW  best minus second-best value; present only with ARGMAX_MARGIN_EN.

Behaviour:
- Reset (synchronous, active-high):
  - state becomes IDLE.
  - busy, out_valid, out_class, out_value and out_margin are all 0.
  - The capture buffer is cleared.
  - Reset asserted mid-scan discards the scan; no out_valid is produced for it.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If start=1 at an edge: latch all N_IN elements into the buffer, set best_val=elem0, best_idx=0, cnt=1.
  - Go to SCAN if N_IN>1, otherwise go to DONE.
  - If start=0, stay in IDLE.
- SCAN:
  - At each edge, compare buffer[cnt] against best_val as signed values.
  - Update best only if strictly greater, so ties keep the lowest index.
  - Increment cnt.
  - On the edge that processes cnt=N_IN-1, load out_class/out_value from the final best and go to DONE.
  - start is ignored while in SCAN (busy=1).
  - in_vec may change freely after the capture edge.
- DONE:
  - out_valid=1 for exactly this cycle.
  - The next edge goes to IDLE.
  - If start=1 in DONE, it is accepted as in IDLE (back-to-back operation): capture and go to SCAN.
- Latency: with the capture at edge E, out_valid is high in the cycle after edge E+N_IN-1. For N_IN=15, that is 14 edges after the capture edge.
- Throughput: one result per N_IN cycles with back-to-back starts.
- out_class, out_value and out_margin change only on the DONE-entry edge or on reset; they are stable otherwise.
- Arithmetic: all comparisons are signed DW-bit. Upstream ReLU nodes emit values in 0..32767, but negative inputs must still order correctly.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- When defined:
  - A second-best value register, initialised to the most-negative value at capture, is tracked.
  - On a new best, the old best moves to second-best; otherwise, if the element is greater than second-best, it replaces second-best.
  - out_margin = best - second, saturated to 2^(DW-1)-1. It is registered together with out_class.
  - For N_IN=1, out_margin = 2^(DW-1)-1.
  - An exact tie gives margin 0.
- When undefined: the out_margin port, the second-best register and the subtractor are absent.

Decomposition:
- Shared package `ann_pkg` holds:
  - ANN_DW=16.
  - The state typedef (IDLE/SCAN/DONE).
  - The saturation constant ANN_MAX_POS.
  - A function for the index width.
- One combinational sub-module, `ann_max_update`, takes the current best/second and the candidate and returns the updated best/second/index-select. It is reused by other reduction stages.

Test Plan:
- N_IN=15, in_vec elements all 0 except elem9=500; pulse start → after 14 edges out_valid=1, out_class=9, out_value=500.
- Tie: elem3=elem11=1200, rest 100 → out_class=3, out_value=1200, margin 0 (with ARGMAX_MARGIN_EN).
- Signed ordering: elem0=-5 (0xFFFB), elem1=-2, rest -100 → out_class=1, out_value=0xFFFE; margin=3.
- Start held high during SCAN → no recapture and no extra out_valid. Start asserted in the DONE cycle with new vector (elem14=7, rest 0) → second out_valid 15 cycles after the first, out_class=14.
- Reset at scan cycle 5 → busy=0 and all outputs 0 the next cycle; no out_valid; a subsequent start produces a correct result.
- Randomised 1000 vectors against a scoreboard argmax (lowest index on tie), checking exact out_valid timing.
